// File: rtl/linebuf_pp.sv
// Ping-pong scanline buffer. The renderer writes bank `linesel` through a
// two-stage read-modify-write pipeline on port A. Video reads bank `!linesel`
// on port B, optionally clearing each entry as it is read.
module linebuf_pp #(
  parameter int unsigned IDX_W       = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RD_W        = 6,
  parameter int unsigned TRANSP_BITS = 4,
  parameter bit          CLR_ON_READ = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              swap,
  output logic              linesel,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_prio,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [RD_W-1:0]   rd_data,
  output logic              rd_valid
);

  localparam int unsigned ADDR_W = IDX_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  // Address is {bank, idx}
  logic [DATA_W-1:0] mem [DEPTH];

  logic              linesel_q;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_prio_q;
  logic              s1_transp_q;  // destination entry was transparent at S0
  logic              rd_pend_q;
  logic [RD_W-1:0]   port_b_q;
  logic [RD_W-1:0]   rd_data_q;
  logic              rd_valid_q;

  logic [ADDR_W-1:0] s0_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              s1_commit;
  logic              fwd;
  logic              clr_en;

  // Address formation, commit decision, forwarding and collision handling
  always_comb begin
    s0_addr   = {linesel_q, wr_idx};
    b_addr    = {~linesel_q, rd_idx};
    s1_commit = s1_valid_q && (!s1_prio_q || s1_transp_q);
    // Follow-on op to the pixel just committed must see the new value, not stale RAM
    fwd       = s1_commit && (s1_addr_q == s0_addr);
    // A colliding port-A commit wins over the clear
    clr_en    = CLR_ON_READ && rd_en && !(s1_commit && (s1_addr_q == b_addr));
  end

  // Dual-port RAM: port A old-value read and commit, port B read-first with optional clear
  always_ff @(posedge clk) begin
    if (s1_commit) begin
      mem[s1_addr_q] <= s1_data_q;
    end
    if (clr_en) begin
      mem[b_addr] <= CLEAR_VAL;
    end
    if (wr_en) begin
      s1_transp_q <= fwd ? (s1_data_q[TRANSP_BITS-1:0] == '0)
                         : (mem[s0_addr][TRANSP_BITS-1:0] == '0);
    end
    if (rd_en) begin
      port_b_q <= mem[b_addr][RD_W-1:0];
    end
  end

  // Bank select, pipeline valids and registered read outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      linesel_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_prio_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (swap) begin
        linesel_q <= ~linesel_q;
      end
      s1_valid_q <= wr_en;
      if (wr_en) begin
        s1_addr_q <= s0_addr;
        s1_data_q <= wr_data;
        s1_prio_q <= wr_prio;
      end
      rd_pend_q  <= rd_en;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= port_b_q;
      end
    end
  end

  assign linesel  = linesel_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_linebuf_pp.sv
// Directed bench for linebuf_pp with default parameters.
module tb_linebuf_pp;

  logic       clk = 1'b0;
  logic       reset;
  logic       swap;
  logic       linesel;
  logic       wr_en;
  logic [8:0] wr_idx;
  logic [7:0] wr_data;
  logic       wr_prio;
  logic       rd_en;
  logic [8:0] rd_idx;
  logic [5:0] rd_data;
  logic       rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  linebuf_pp dut (
    .clk      (clk),
    .reset    (reset),
    .swap     (swap),
    .linesel  (linesel),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_prio  (wr_prio),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  // One write issued at the next edge; wr_en left low afterwards
  task automatic wr(input int idx, input logic [7:0] data, input logic prio);
    wr_en   = 1'b1;
    wr_idx  = 9'(idx);
    wr_data = data;
    wr_prio = prio;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input int idx, input logic [5:0] exp);
    rd_en  = 1'b1;
    rd_idx = 9'(idx);
    tick();
    rd_en  = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  // 512 back-to-back reads; result for index c-1 appears after edge c
  task automatic stream(input string tag, input bit zero);
    for (int c = 0; c <= 512; c++) begin
      if (c < 512) begin
        rd_en  = 1'b1;
        rd_idx = 9'(c);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (c >= 1) begin
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), zero ? 32'd0 : 32'((c - 1) & 63));
      end
    end
    tick();
    check({tag, "_drain"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; swap = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_prio = 1'b0;
    rd_en = 1'b0; rd_idx = '0;
    repeat (2) tick();
    check("rst_linesel", 32'(linesel), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // Basic write/swap/read, then clear-on-read (linesel 0 -> 1)
    wr(5, 8'h2A, 1'b0);
    tick();
    do_swap();
    check("swap_linesel", 32'(linesel), 32'd1);
    rd("basic", 5, 6'h2A);
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'h2A);
    do_swap();
    do_swap();
    rd("cleared", 5, 6'h00);

    // Prio into bank 1: opaque existing entry kept
    wr(10, 8'h13, 1'b0);
    wr(10, 8'h25, 1'b1);
    tick();
    do_swap();
    rd("prio_keep", 10, 6'h13);
    // Prio into bank 0: transparent existing entry overwritten
    wr(10, 8'h10, 1'b0);
    wr(10, 8'h25, 1'b1);
    tick();
    do_swap();
    rd("prio_over", 10, 6'h25);
    // Prio with a gap between writes (RAM path, no forwarding), bank 1
    wr(11, 8'h13, 1'b0);
    tick();
    wr(11, 8'h25, 1'b1);
    tick();
    do_swap();
    rd("prio_gap", 11, 6'h13);

    // Forwarding on bank 0: first opaque prio write wins
    wr(7, 8'h00, 1'b0);
    wr(7, 8'h31, 1'b1);
    wr(7, 8'h42, 1'b1);
    tick();
    do_swap();
    rd("fwd", 7, 6'h31);

    // Streaming into bank 1
    for (int i = 0; i < 512; i++) begin
      wr_en = 1'b1; wr_idx = 9'(i); wr_data = 8'(i); wr_prio = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    tick();
    do_swap();
    stream("stream", 1'b0);
    do_swap();
    do_swap();
    stream("stream_clr", 1'b1);

    // Write issued with swap: lands in bank 0 (linesel 0 before the edge)
    check("pre_swapwr_linesel", 32'(linesel), 32'd0);
    swap = 1'b1;
    wr(3, 8'h07, 1'b0);
    swap = 1'b0;
    tick();
    check("swapwr_linesel", 32'(linesel), 32'd1);
    rd("swapwr_bank0", 3, 6'h07);
    do_swap();
    rd("swapwr_bank1", 3, 6'h00);

    // Async reset with a write in S0 (bank 1 is the write bank here)
    do_swap();
    wr(20, 8'h11, 1'b0);
    tick();
    rd_en = 1'b1; rd_idx = 9'd0;
    tick();
    rd_en = 1'b0;
    wr(20, 8'h2F, 1'b0);
    check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_linesel", 32'(linesel), 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rd_data", 32'(rd_data), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    rd("rst_dropped_wr", 20, 6'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/linebuf_pp.md
Name: linebuf_pp

Overview:
- Parametrised ping-pong scanline buffer between the line renderer (write side) and the video output (read side).
- Two banks of 2^IDX_W entries. The renderer fills bank `linesel` while video scans out bank `!linesel`. Banks toggle on a `swap` pulse.
- Adds two features over a plain line buffer:
  - per-write priority mode: a read-modify-write that keeps an existing opaque pixel;
  - optional clear-on-read, so a scanned-out line is blank when it becomes the render bank again.
- Maps onto one true-dual-port block RAM plus a small pipeline.

Parameters:
- IDX_W, 9, pixel index width; each bank holds 2^IDX_W entries.
- DATA_W, 8, stored entry width.
- RD_W, 6, read-port width; rd_data carries stored[RD_W-1:0]. Must satisfy RD_W <= DATA_W.
- TRANSP_BITS, 4, an entry is transparent when stored[TRANSP_BITS-1:0] == 0.
- CLR_ON_READ, 1, 1 = each read also writes CLEAR_VAL to the location it reads.
- CLEAR_VAL, 0, value written by clear-on-read (DATA_W wide).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- swap  in  1  single-cycle pulse; toggles linesel.
- linesel  out  1  current write bank; the read bank is !linesel.
- wr_en  in  1  write request. Accepted every cycle; there is no backpressure.
- wr_idx  in  IDX_W  write pixel index.
- wr_data  in  DATA_W  write data.
- wr_prio  in  1  1 = write only if the destination entry is transparent.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  read pixel index.
- rd_data  out  RD_W  read data.
- rd_valid  out  1  rd_data updated this cycle.

Behaviour:
- Reset values (asynchronous): linesel=0, rd_valid=0, rd_data=0. Write and read pipeline valid bits are cleared, so any in-flight write is dropped. RAM contents are not cleared.
- Bank switch: a swap sampled high at edge n makes linesel invert from edge n onward. Every operation latches its bank at issue, so a swap only affects requests issued after it.
- RAM addressing: {bank, idx}. Port A serves the write side; port B serves the read side.
- Write pipeline (2 stages, 1 op/cycle):
  - S0, cycle of wr_en: register idx, data, prio and bank. Port A reads the old entry.
  - S1, next cycle: commit the write if prio==0, or if old[TRANSP_BITS-1:0]==0. Otherwise drop it silently.
  - Result is visible to a later S0 read from the cycle after the commit.
- Write forwarding: if S1 commits to {bank,idx} and S0 of the following op targets the same {bank,idx}, that op's old value is the committed S1 data, not the RAM output. Consecutive prio writes to one pixel therefore behave sequentially: the first opaque write wins.
- Read path:
  - rd_en at edge n: port B reads {!linesel, rd_idx}.
  - At edge n+1: rd_data = entry[RD_W-1:0] and rd_valid=1.
  - Without rd_en, rd_valid=0 and rd_data holds its previous value.
  - Back-to-back reads give one result per cycle.
- Clear-on-read (CLR_ON_READ=1):
  - Port B operates read-first and writes CLEAR_VAL to the read address in the same cycle.
  - The read returns the pre-clear value.
- Collision: an S1 commit and a port-B access hit the same address in the same cycle. This is only possible after a swap with a write still in flight. In that case:
  - the port-A write wins;
  - the port-B read returns the pre-write value;
  - the clear write is discarded.
- Indices wrap naturally at 2^IDX_W; no range check is made.
- wr_en and rd_en may be asserted simultaneously with swap. Each op uses the linesel value from before the edge.

Test Plan:
- Reset, then write idx 5 = 0x2A (prio=0) in bank 0, pulse swap, rd_en idx 5 -> rd_valid after 1 cycle, rd_data = 0x2A & 0x3F = 0x2A. Then swap twice and read idx 5 again -> 0x00 (cleared by CLR_ON_READ=1).
- Prio: write idx 10 = 0x13 (prio=0), then idx 10 = 0x25 (prio=1), swap, read -> 0x13. Repeat with first value 0x10 (low nibble 0) -> 0x25.
- Forwarding: back-to-back writes to idx 7, first 0x31 (prio=1), second 0x42 (prio=1), on a cleared line -> read gives 0x31.
- Streaming: fill idx 0..511 with idx[7:0], swap, rd_en held for 512 cycles -> rd_valid continuous, rd_data = idx[5:0] each cycle. Re-read after two swaps -> all 0.
- Swap mid-write: wr_en idx 3 = 0x07 in the same cycle as swap -> data lands in the old bank (0), visible on the read side; bank 1 idx 3 is unchanged.
- Async reset asserted while wr_en is in S0 -> linesel=0, rd_valid=0 immediately. The pending write is not committed; the target entry keeps its prior value.
